instr_loader: RTL and testbench

- Sequential writer for the single-cycle MIPS instruction memory; the encode-side counterpart of the opcode decoder.
- Accepts instruction fields over a valid/ready handshake and encodes them into 32-bit MIPS words.
- Supported opcodes: R_FORMAT, LW, SW, BEQ, BNE, J, ADDI.
- Writes words sequentially into instruction memory and holds the CPU until the program image is complete.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/instr_loader_if.sv | 43 ++++
 rtl/instr_encode.sv | 30 +++
 rtl/instr_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode, field-width and loader-state definitions
// Shared by instr_encode, instr_loader_if and instr_loader.
// Optional feature macro: LOADER_NOP_PAD_EN (adds the PAD loader state).
package mips_pkg;

    localparam int OP_W     = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;
    localparam int WORD_W   = 32;

    localparam logic [OP_W-1:0] R_FORMAT = 6'd0;
    localparam logic [OP_W-1:0] J        = 6'd2;
    localparam logic [OP_W-1:0] BEQ      = 6'd4;
    localparam logic [OP_W-1:0] BNE      = 6'd5;
    localparam logic [OP_W-1:0] ADDI     = 6'd8;
    localparam logic [OP_W-1:0] LW       = 6'd35;
    localparam logic [OP_W-1:0] SW       = 6'd43;

    // Reported in err_op when the program does not fit in memory.
    localparam logic [OP_W-1:0] OVF_CODE = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
`ifdef LOADER_NOP_PAD_EN
        ST_PAD,
`endif
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - field-bundle handshake, memory write and status bundle
// master: program source (drives start and field bundles, observes status).
// slave : instr_loader (accepts bundles, drives memory write port and status).
interface instr_loader_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) ();
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in_op;
    logic [REG_W-1:0]    in_rs;
    logic [REG_W-1:0]    in_rt;
    logic [REG_W-1:0]    in_rd;
    logic [REG_W-1:0]    in_shamt;
    logic [FUNCT_W-1:0]  in_funct;
    logic [IMM_W-1:0]    in_imm;
    logic [TARGET_W-1:0] in_target;
    logic                in_last;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                cpu_hold;
    logic                done;
    logic                err;
    logic [OP_W-1:0]     err_op;
    logic [ADDR_W:0]     count;

    modport master (
        output start, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
               err, err_op, count
    );

    modport slave (
        input  start, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
               err, err_op, count
    );
endinterface

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - combinational MIPS field-to-word encoder
// Ports: i_op/i_rs/i_rt/i_rd/i_shamt/i_funct/i_imm/i_target fields in,
//        o_word encoded instruction, o_legal high for supported opcodes.
module instr_encode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]     i_op,
    input  logic [REG_W-1:0]    i_rs,
    input  logic [REG_W-1:0]    i_rt,
    input  logic [REG_W-1:0]    i_rd,
    input  logic [REG_W-1:0]    i_shamt,
    input  logic [FUNCT_W-1:0]  i_funct,
    input  logic [IMM_W-1:0]    i_imm,
    input  logic [TARGET_W-1:0] i_target,
    output logic [WORD_W-1:0]   o_word,
    output logic                o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_op)
            R_FORMAT:                o_word = {R_FORMAT, i_rs, i_rt, i_rd, i_shamt, i_funct};
            LW, SW, BEQ, BNE, ADDI:  o_word = {i_op, i_rs, i_rt, i_imm};
            J:                       o_word = {i_op, i_target};
            default:                 o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - sequential instruction-memory loader holding the CPU until loaded
// Ports: clk, reset (async active-low), bus (instr_loader_if.slave):
//        start pulse, field bundle valid/ready/last, memory write port
//        (mem_we/mem_addr/mem_wdata), cpu_hold, done, err, err_op, count.
// Optional feature macro: LOADER_NOP_PAD_EN - zero-fill remaining addresses
//        after the last word before signalling done.
module instr_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    instr_loader_if.slave   bus
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    loader_state_t       r_state;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_err;
    logic [OP_W-1:0]     r_err_op;
    logic [ADDR_W:0]     r_count;
    logic                r_last;

    logic [WORD_W-1:0]   w_word;
    logic                w_legal;
    logic                w_accept;
    logic                w_top;

    instr_encode u_encode (
        .i_op     (bus.in_op),
        .i_rs     (bus.in_rs),
        .i_rt     (bus.in_rt),
        .i_rd     (bus.in_rd),
        .i_shamt  (bus.in_shamt),
        .i_funct  (bus.in_funct),
        .i_imm    (bus.in_imm),
        .i_target (bus.in_target),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // r_in_ready is only ever high in LOAD, so this is the LOAD handshake.
    assign w_accept = bus.in_valid & r_in_ready;
    assign w_top    = (r_mem_addr == ADDR_TOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_op    <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        r_state    <= ST_LOAD;
                        r_in_ready <= 1'b1;
                        r_mem_addr <= BASE;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_op   <= '0;
                        r_count    <= '0;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_legal) begin
                            r_state     <= ST_WRITE;
                            r_mem_wdata <= w_word;
                            r_mem_we    <= 1'b1;
                            // The source may drop in_last after the handshake.
                            r_last      <= bus.in_last;
                        end else begin
                            r_state  <= ST_ERROR;
                            r_err    <= 1'b1;
                            r_err_op <= bus.in_op;
                        end
                    end
                end

                ST_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_count  <= r_count + (ADDR_W+1)'(1);
                    if (r_last) begin
`ifdef LOADER_NOP_PAD_EN
                        if (!w_top) begin
                            // Zero (NOP) fill starts at the next address.
                            r_state     <= ST_PAD;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                            r_mem_wdata <= '0;
                            r_mem_we    <= 1'b1;
                        end else begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end
`else
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
`endif
                    end else if (w_top) begin
                        // Memory is full but the program has more words.
                        r_state  <= ST_ERROR;
                        r_err    <= 1'b1;
                        r_err_op <= OVF_CODE;
                    end else begin
                        r_state    <= ST_LOAD;
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_in_ready <= 1'b1;
                    end
                end

`ifdef LOADER_NOP_PAD_EN
                ST_PAD: begin
                    r_count <= r_count + (ADDR_W+1)'(1);
                    if (w_top) begin
                        r_state    <= ST_DONE;
                        r_mem_we   <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                end
`endif

                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.err_op    = r_err_op;
    assign bus.count     = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;
    import mips_pkg::*;

`ifdef LOADER_NOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_start, s_valid, s_last;
    logic [5:0]  s_op, s_fn;
    logic [4:0]  s_rs, s_rt, s_rd, s_sh;
    logic [15:0] s_imm;
    logic [25:0] s_tgt;
    int          sel;

    int n_total = 0;
    int n_pass  = 0;
    int we_cnt  = 0;

    instr_loader_if #(.ADDR_W(6)) bus6 ();
    instr_loader_if #(.ADDR_W(2)) bus2 ();
    instr_loader_if #(.ADDR_W(3)) bus3 ();

    instr_loader #(.ADDR_W(6), .BASE_ADDR(0)) u_dut6 (.clk(clk), .reset(rst_n), .bus(bus6));
    instr_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
    instr_loader #(.ADDR_W(3), .BASE_ADDR(0)) u_dut3 (.clk(clk), .reset(rst_n), .bus(bus3));

    assign bus6.start = s_start;  assign bus2.start = s_start;  assign bus3.start = s_start;
    assign bus6.in_valid = s_valid;  assign bus2.in_valid = s_valid;  assign bus3.in_valid = s_valid;
    assign bus6.in_op = s_op;  assign bus2.in_op = s_op;  assign bus3.in_op = s_op;
    assign bus6.in_rs = s_rs;  assign bus2.in_rs = s_rs;  assign bus3.in_rs = s_rs;
    assign bus6.in_rt = s_rt;  assign bus2.in_rt = s_rt;  assign bus3.in_rt = s_rt;
    assign bus6.in_rd = s_rd;  assign bus2.in_rd = s_rd;  assign bus3.in_rd = s_rd;
    assign bus6.in_shamt = s_sh;  assign bus2.in_shamt = s_sh;  assign bus3.in_shamt = s_sh;
    assign bus6.in_funct = s_fn;  assign bus2.in_funct = s_fn;  assign bus3.in_funct = s_fn;
    assign bus6.in_imm = s_imm;  assign bus2.in_imm = s_imm;  assign bus3.in_imm = s_imm;
    assign bus6.in_target = s_tgt;  assign bus2.in_target = s_tgt;  assign bus3.in_target = s_tgt;
    assign bus6.in_last = s_last;  assign bus2.in_last = s_last;  assign bus3.in_last = s_last;

    logic        o_ready, o_we, o_hold, o_done, o_err;
    logic [5:0]  o_addr, o_errop;
    logic [31:0] o_wdata;
    logic [6:0]  o_count;

    always_comb begin
        o_ready = bus6.in_ready;  o_we = bus6.mem_we;  o_addr = bus6.mem_addr;
        o_wdata = bus6.mem_wdata; o_hold = bus6.cpu_hold; o_done = bus6.done;
        o_err = bus6.err;  o_errop = bus6.err_op;  o_count = bus6.count;
        if (sel == 1) begin
            o_ready = bus2.in_ready;  o_we = bus2.mem_we;  o_addr = 6'(bus2.mem_addr);
            o_wdata = bus2.mem_wdata; o_hold = bus2.cpu_hold; o_done = bus2.done;
            o_err = bus2.err;  o_errop = bus2.err_op;  o_count = 7'(bus2.count);
        end else if (sel == 2) begin
            o_ready = bus3.in_ready;  o_we = bus3.mem_we;  o_addr = 6'(bus3.mem_addr);
            o_wdata = bus3.mem_wdata; o_hold = bus3.cpu_hold; o_done = bus3.done;
            o_err = bus3.err;  o_errop = bus3.err_op;  o_count = 7'(bus3.count);
        end
    end

    always @(posedge clk) if (o_we) we_cnt <= we_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int fin(input int n, input int aw);
        return PAD_EN ? (1 << aw) : n;
    endfunction

    task automatic do_start();
        if (PAD_EN) repeat (70) @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic send(input string tag, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input bit exp_write, input logic [5:0] exp_addr,
                        input logic [31:0] exp_word);
        int n = 0;
        s_op = op; s_rs = rs; s_rt = rt; s_rd = rd; s_sh = sh; s_fn = fn;
        s_imm = imm; s_tgt = tgt; s_last = last; s_valid = 1'b1;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            check({tag, ".ready_timeout"}, 32'(o_ready), 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check({tag, ".we"}, 32'(o_we), 32'(exp_write));
        if (exp_write) begin
            check({tag, ".addr"}, 32'(o_addr), 32'(exp_addr));
            check({tag, ".wdata"}, o_wdata, exp_word);
        end
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(o_done || o_err) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".finished"}, 32'(o_done || o_err), 32'd1);
    endtask

    initial begin
        int wb;
        rst_n = 1'b0; sel = 0;
        s_start = 0; s_valid = 0; s_last = 0; s_op = 0; s_rs = 0; s_rt = 0; s_rd = 0;
        s_sh = 0; s_fn = 0; s_imm = 0; s_tgt = 0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(o_ready), 0);
        check("rst.we", 32'(o_we), 0);
        check("rst.addr", 32'(o_addr), 0);
        check("rst.wdata", o_wdata, 0);
        check("rst.hold", 32'(o_hold), 1);
        check("rst.done", 32'(o_done), 0);
        check("rst.err", 32'(o_err), 0);
        check("rst.errop", 32'(o_errop), 0);
        check("rst.count", 32'(o_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.ready", 32'(o_ready), 0);

        // R-format add
        do_start();
        check("radd.ready_after_start", 32'(o_ready), 1);
        send("radd", R_FORMAT, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32, 16'h0, 26'h0, 1'b1, 1'b1, 6'd0, 32'h00221820);
        wait_end("radd");
        check("radd.done", 32'(o_done), 1);
        check("radd.hold", 32'(o_hold), 0);
        check("radd.count", 32'(o_count), 32'(fin(1, 6)));

        // Mixed lw / beq / j
        do_start();
        check("mix.done_cleared", 32'(o_done), 0);
        check("mix.count_cleared", 32'(o_count), 0);
        send("mix.lw", LW, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 6'd0, 32'h8C220004);
        send("mix.beq", BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 6'd1, 32'h1022FFFF);
        send("mix.j", J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b1, 1'b1, 6'd2, 32'h08000010);
        wait_end("mix");
        check("mix.done", 32'(o_done), 1);
        check("mix.count", 32'(o_count), 32'(fin(3, 6)));

        // sll / sw / addi / bne with junk in the unused fields
        do_start();
        send("misc.sll", R_FORMAT, 5'd0, 5'd5, 5'd4, 5'd3, 6'd0, 16'hFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 6'd0, 32'h000520C0);
        send("misc.sw", SW, 5'd5, 5'd6, 5'd31, 5'd31, 6'h3F, 16'h8000, 26'h3FFFFFF, 1'b0, 1'b1, 6'd1, 32'hACA68000);
        send("misc.addi", ADDI, 5'd0, 5'd8, 5'd7, 5'd7, 6'h15, 16'h0010, 26'h155AAAA, 1'b0, 1'b1, 6'd2, 32'h20080010);
        send("misc.bne", BNE, 5'd31, 5'd31, 5'd1, 5'd2, 6'h2A, 16'h1234, 26'h0, 1'b1, 1'b1, 6'd3, 32'h17FF1234);
        wait_end("misc");
        check("misc.count", 32'(o_count), 32'(fin(4, 6)));

        // Illegal opcode, then recovery
        do_start();
        wb = we_cnt;
        send("ill", 6'd13, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0, 1'b0, 6'd0, 32'h0);
        check("ill.err", 32'(o_err), 1);
        check("ill.errop", 32'(o_errop), 13);
        check("ill.ready", 32'(o_ready), 0);
        check("ill.hold", 32'(o_hold), 1);
        check("ill.done", 32'(o_done), 0);
        @(negedge clk);
        check("ill.no_writes", we_cnt - wb, 0);
        do_start();
        check("ill.recover_ready", 32'(o_ready), 1);
        check("ill.recover_err", 32'(o_err), 0);
        check("ill.recover_errop", 32'(o_errop), 0);
        send("ill.j", J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF, 1'b1, 1'b1, 6'd0, 32'h0BFFFFFF);
        wait_end("ill.j");

        // Overflow with ADDR_W=2
        sel = 1;
        do_start();
        for (int k = 0; k < 4; k++)
            send($sformatf("ovf.w%0d", k), ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(k), 26'h0,
                 1'b0, 1'b1, 6'(k), 32'h20080000 + 32'(k));
        @(negedge clk);
        check("ovf.err", 32'(o_err), 1);
        check("ovf.errop", 32'(o_errop), 32'h3F);
        check("ovf.count", 32'(o_count), 4);
        check("ovf.hold", 32'(o_hold), 1);
        wb = we_cnt;
        s_valid = 1'b1; s_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ovf.blocked%0d", k), 32'(o_ready), 0);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("ovf.no_fifth_write", we_cnt - wb, 0);

        // Last word exactly on the top address
        do_start();
        for (int k = 0; k < 4; k++)
            send($sformatf("top.w%0d", k), ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(k), 26'h0,
                 (k == 3), 1'b1, 6'(k), 32'h20080000 + 32'(k));
        wait_end("top");
        check("top.done", 32'(o_done), 1);
        check("top.err", 32'(o_err), 0);
        check("top.count", 32'(o_count), 4);
        check("top.addr", 32'(o_addr), 3);

        // Continuous valid: one acceptance every second cycle, then async reset in WRITE
        sel = 0;
        do_start();
        s_op = ADDI; s_rs = 0; s_rt = 8; s_imm = 16'h0; s_last = 0; s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tput.ready%0d", i), 32'(o_ready), 32'(i % 2 == 0));
            check($sformatf("tput.we%0d", i), 32'(o_we), 32'(i % 2 == 1));
            if (i < 7) @(negedge clk);
        end
        check("tput.addr_at_4th", 32'(o_addr), 3);
        rst_n = 1'b0;
        #1;
        s_valid = 1'b0;
        check("arst.we", 32'(o_we), 0);
        check("arst.ready", 32'(o_ready), 0);
        check("arst.addr", 32'(o_addr), 0);
        check("arst.wdata", o_wdata, 0);
        check("arst.hold", 32'(o_hold), 1);
        check("arst.count", 32'(o_count), 0);
        check("arst.done", 32'(o_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef LOADER_NOP_PAD_EN
        // Zero padding with ADDR_W=3
        sel = 2;
        do_start();
        send("pad.w0", ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h1, 26'h0, 1'b0, 1'b1, 6'd0, 32'h20080001);
        send("pad.w1", ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h2, 26'h0, 1'b1, 1'b1, 6'd1, 32'h20080002);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("pad.we%0d", k), 32'(o_we), 1);
            check($sformatf("pad.addr%0d", k), 32'(o_addr), 32'(2 + k));
            check($sformatf("pad.wdata%0d", k), o_wdata, 0);
        end
        @(negedge clk);
        check("pad.done", 32'(o_done), 1);
        check("pad.count", 32'(o_count), 8);
        check("pad.we_off", 32'(o_we), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
